program_loader: RTL
===================

Name: program_loader

Overview:
- Instruction source for the 8-bit single-cycle datapath.
- Holds a program RAM that is filled byte-by-byte over a valid/ready load port.
- While loading, it keeps the CPU held and feeds it NOPs.
- Once running, it returns the instruction stored at the CPU's current PC, combinationally, with the same timing as a ROM.

Parameters:
- DEPTH, 256, number of program words; the address width is fixed at 8, so DEPTH is at most 256.
- NOP_WORD, 8'h00, instruction word driven whenever no valid program word applies.

Ports:
- CLK  input  1  system clock, same clock that advances the datapath PC.
- RESET  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle pulse: begin a new program load.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  8  program byte.
- load_last  input  1  qualifies load_data as the final byte.
- load_ready  output  1  loader accepts a byte this cycle.
- run_start  input  1  single-cycle pulse: leave IDLE and run the current program.
- PC  input  8  program counter from the datapath.
- instruction  output  8  instruction word to the datapath.
- cpu_run  output  1  high only in RUN; low holds the datapath (integration ties it into the datapath reset).
- prog_len  output  9  number of valid program words (0..DEPTH).
- checksum  output  8  XOR of loaded bytes (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, prog_len=0, load_ready=0, cpu_run=0, checksum=0. RAM contents are not cleared.
- FSM states are IDLE, LOAD, RUN. All transitions are registered on the CLK rising edge.
- IDLE:
  - load_ready=0, cpu_run=0.
  - load_start -> LOAD.
  - Else run_start -> RUN.
  - If both pulse in the same cycle, load_start wins.
- LOAD:
  - load_ready=1.
  - Entry (from any state) sets wr_ptr=0 and prog_len=0.
  - A byte is accepted on load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1, prog_len<=prog_len+1.
  - Accepting a byte with load_last=1 -> RUN on the next cycle.
  - Accepting the DEPTH-th byte -> RUN regardless of load_last. There is no wrap and no overwrite of word 0.
  - load_start during LOAD restarts the load (wr_ptr=0, prog_len=0). If a byte is offered in that same cycle, it is dropped.
  - load_valid with load_last while prog_len==0 is legal; the result is a 1-word program.
- RUN:
  - cpu_run=1, load_ready=0.
  - load_start -> LOAD; cpu_run falls on the next edge.
  - run_start is ignored.
- instruction output (combinational):
  - In RUN with PC < prog_len: instruction = mem[PC].
  - Otherwise (IDLE, LOAD, or PC >= prog_len): instruction = NOP_WORD.
  - Zero cycles of latency from PC to instruction.
- run_start from IDLE with prog_len==0 enters RUN and fetches NOP_WORD only.
- An asynchronous reset mid-load aborts immediately. prog_len returns to 0, so any partial RAM contents are unreachable.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - checksum is cleared on LOAD entry.
  - checksum <= checksum ^ load_data on each accepted byte.
  - checksum holds its value through RUN.
- Disabled: checksum is tied to 8'h00 and no checksum register exists. The port list does not change.

Decomposition:
- Shared package program_loader_pkg:
  - state enum (IDLE=2'd0, LOAD=2'd1, RUN=2'd2);
  - ADDR_W=8;
  - default NOP_WORD.
- One sub-module, program_ram: DEPTH x 8, synchronous write, asynchronous read. The FSM, pointers, NOP muxing and checksum stay in the top module.

Test Plan:
- Reset then idle: RESET low for 3 cycles, then release, then PC=8'h05 -> instruction=8'h00, cpu_run=0, load_ready=0, prog_len=0.
- Basic load and run:
  - Stimulus: load_start, then bytes 8'h41, 8'h82, 8'hC3 with load_last on 8'hC3.
  - Response: cpu_run=1 on the cycle after the last byte, prog_len=3.
  - PC=0/1/2 -> 41/82/C3; PC=3 -> 00.
- Backpressure: drive load_valid=0 for random gaps during the load -> RAM and prog_len change only on cycles where load_valid & load_ready.
- Full depth: load 256 bytes 0..255 with load_last never asserted -> RUN after byte 255, prog_len=256, PC=8'hFF -> 8'hFF.
- Restart and abort:
  - Reload in RUN: load_start -> cpu_run=0 next cycle, instruction=00, prog_len=0.
  - Reset mid-load: assert RESET low after 2 bytes -> IDLE, prog_len=0.
- Checksum (macro defined): load bytes 8'h0F, 8'hF0, 8'h33 -> checksum=8'hCC. With the macro undefined -> checksum=8'h00.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding, address width and default NOP word
package program_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int ADDR_W = 8;
    localparam logic [7:0] NOP_WORD_DEFAULT = 8'h00;

endpackage

// File: rtl/program_ram.sv
// program_ram: DEPTH x 8 program store, synchronous write, asynchronous read
module program_ram
    import program_loader_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are deliberately never reset; prog_len gates what is reachable.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// program_loader: byte-loaded program RAM feeding the datapath; optional XOR checksum via PROGRAM_LOADER_CHECKSUM_EN
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic       run_start,
    input  logic [7:0] PC,
    output logic [7:0] instruction,
    output logic       cpu_run,
    output logic [8:0] prog_len,
    output logic [7:0] checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [8:0]        len_q, len_d;
    logic              accept;
    logic [7:0]        rdata;

    // Next state and pointer update; load_start always restarts the load and drops any byte offered with it.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        load_ready = (state_q == LOAD);
        cpu_run    = (state_q == RUN);
        accept     = load_ready && load_valid && !load_start;
        if (load_start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            len_d    = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 8'd1;
            len_d    = len_q + 9'd1;
            if (load_last || len_q == 9'(DEPTH - 1)) state_d = RUN;
        end else if (state_q == IDLE && run_start) begin
            state_d = RUN;
        end
    end

    // State, write pointer and program length registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
        end
    end

    program_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (CLK),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .raddr_i (PC),
        .rdata_o (rdata)
    );

    assign prog_len    = len_q;
    assign instruction = (state_q == RUN && {1'b0, PC} < len_q) ? rdata : NOP_WORD;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] ck_q, ck_d;

    // Running XOR of accepted bytes, cleared when a new load begins.
    always_comb ck_d = load_start ? 8'h00 : accept ? ck_q ^ load_data : ck_q;

    // Checksum register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) ck_q <= 8'h00;
        else        ck_q <= ck_d;
    end

    assign checksum = ck_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
